// File: rtl/cnu_pkg.sv
// rtl/cnu_pkg.sv - shared widths, sentinels and state encoding for the serial check-node minimum accumulator
package cnu_pkg;

  localparam int ABS_WID  = 6;            // magnitude width
  localparam int MIN_NUM  = 3;            // minima tracked
  localparam int MAX_DEG  = 32;           // largest legal row degree
  localparam int DEG_WID  = 6;            // holds 0..MAX_DEG
  localparam int IDX_WID  = 5;            // global beat position, clog2(MAX_DEG)

  // The sorter sees the running minima plus the incoming beat
  localparam int SORT_IN  = MIN_NUM + 1;
  localparam int LIDX_WID = 2;            // local sorter index, clog2(SORT_IN)

  // All-ones sentinels mark slots not yet filled by a real beat
  localparam logic [ABS_WID-1:0] ABS_MAX  = '1;
  localparam logic [IDX_WID-1:0] IDX_NONE = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cnu_min_seq_min.sv
// rtl/cnu_min_seq_min.sv - combinational sorter returning the MIN_NUM smallest of IN_NUM values with their input positions
module min #(
  parameter int IN_NUM   = 4,
  parameter int MIN_NUM  = 3,
  parameter int DATA_WID = 6,
  parameter int IDX_WID  = 2
) (
  input  logic [IN_NUM*DATA_WID-1:0]  vals,
  output logic [MIN_NUM*DATA_WID-1:0] mins,
  output logic [MIN_NUM*IDX_WID-1:0]  min_idx
);

  // Rank counts up to IN_NUM-1, so this width is always sufficient
  localparam int RANK_WID = $clog2(IN_NUM);

  logic [DATA_WID-1:0] v    [IN_NUM];
  logic [RANK_WID-1:0] rank [IN_NUM];

  // Unpack the flat input bus, input 0 at the LSB
  always_comb begin
    for (int i = 0; i < IN_NUM; i++) begin
      v[i] = vals[i*DATA_WID +: DATA_WID];
    end
  end

  // Rank each input; equal values rank the lower input first, so ranks form a permutation
  always_comb begin
    for (int i = 0; i < IN_NUM; i++) begin
      rank[i] = '0;
      for (int j = 0; j < IN_NUM; j++) begin
        if (j < i) begin
          if (v[j] <= v[i]) rank[i] = rank[i] + RANK_WID'(1);
        end else if (j > i) begin
          if (v[j] < v[i]) rank[i] = rank[i] + RANK_WID'(1);
        end
      end
    end
  end

  // Route the inputs holding ranks 0..MIN_NUM-1 to the output slots, smallest at the LSB
  always_comb begin
    mins    = '0;
    min_idx = '0;
    for (int k = 0; k < MIN_NUM; k++) begin
      for (int i = 0; i < IN_NUM; i++) begin
        if (rank[i] == RANK_WID'(k)) begin
          mins[k*DATA_WID +: DATA_WID]   = v[i];
          min_idx[k*IDX_WID +: IDX_WID]  = IDX_WID'(i);
        end
      end
    end
  end

endmodule

// File: rtl/cnu_min_seq.sv
// rtl/cnu_min_seq.sv - serial min-sum check-node accumulator: three smallest magnitudes, positions and sign parity per row
module cnu_min_seq
  import cnu_pkg::*;
(
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  input  logic [DEG_WID-1:0]         i_deg,
  output logic                       o_busy,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [ABS_WID-1:0]         i_data,
  input  logic                       i_sign,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [ABS_WID*MIN_NUM-1:0] o_data,
  output logic [IDX_WID*MIN_NUM-1:0] o_idx,
  output logic                       o_sign
);

  state_t state;
  state_t state_nxt;

  logic [DEG_WID-1:0]         cnt;
  logic [DEG_WID-1:0]         deg_last;
  logic [ABS_WID*MIN_NUM-1:0] min_q;
  logic [IDX_WID*MIN_NUM-1:0] idx_q;
  logic                       sign_q;

  logic                        row_start;
  logic                        beat_acc;
  logic                        last_beat;
  logic [ABS_WID*MIN_NUM-1:0]  sort_min;
  logic [LIDX_WID*MIN_NUM-1:0] sort_lidx;
  logic [IDX_WID*MIN_NUM-1:0]  idx_nxt;

  assign row_start = (state == IDLE) && i_start;
  assign beat_acc  = i_valid && o_ready;
  assign last_beat = beat_acc && (cnt == deg_last);

  // Running minima on the low inputs so that on ties the earlier beat keeps its slot
  min #(
    .IN_NUM   (SORT_IN),
    .MIN_NUM  (MIN_NUM),
    .DATA_WID (ABS_WID),
    .IDX_WID  (LIDX_WID)
  ) u_min (
    .vals    ({i_data, min_q}),
    .mins    (sort_min),
    .min_idx (sort_lidx)
  );

  // Translate sorter-local positions into global beat positions
  always_comb begin
    logic [LIDX_WID-1:0] lidx;
    lidx    = '0;
    idx_nxt = '0;
    for (int k = 0; k < MIN_NUM; k++) begin
      lidx = sort_lidx[k*LIDX_WID +: LIDX_WID];
      if (lidx == LIDX_WID'(MIN_NUM)) begin
        idx_nxt[k*IDX_WID +: IDX_WID] = cnt[IDX_WID-1:0];
      end else begin
        idx_nxt[k*IDX_WID +: IDX_WID] = idx_q[lidx*IDX_WID +: IDX_WID];
      end
    end
  end

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: a zero-degree row goes straight to DONE with sentinels only
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (i_start) begin
          state_nxt = (i_deg == '0) ? DONE : ACC;
        end
      end
      ACC: begin
        if (last_beat) state_nxt = DONE;
      end
      DONE: begin
        if (i_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from state
  always_comb begin
    o_ready = 1'b0;
    o_valid = 1'b0;
    o_busy  = 1'b0;
    case (state)
      ACC: begin
        o_ready = 1'b1;
        o_busy  = 1'b1;
      end
      DONE: begin
        o_valid = 1'b1;
        o_busy  = 1'b1;
      end
      default: ;
    endcase
  end

  // Result registers; they change only on row start or an accepted beat, so DONE holds them
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      min_q    <= {MIN_NUM{ABS_MAX}};
      idx_q    <= {MIN_NUM{IDX_NONE}};
      sign_q   <= 1'b0;
      cnt      <= '0;
      deg_last <= '0;
    end else if (row_start) begin
      min_q    <= {MIN_NUM{ABS_MAX}};
      idx_q    <= {MIN_NUM{IDX_NONE}};
      sign_q   <= 1'b0;
      cnt      <= '0;
      deg_last <= i_deg - DEG_WID'(1);
    end else if (beat_acc) begin
      min_q    <= sort_min;
      idx_q    <= idx_nxt;
      sign_q   <= sign_q ^ i_sign;
      cnt      <= cnt + DEG_WID'(1);
    end
  end

  assign o_data = min_q;
  assign o_idx  = idx_q;
  assign o_sign = sign_q;

  // Degrees above MAX_DEG would overflow the position field
  assert property (@(posedge i_clk) disable iff (i_rst)
    row_start |-> (i_deg <= DEG_WID'(MAX_DEG)));

endmodule

// File: tb/tb_cnu_min_seq.sv
// tb/tb_cnu_min_seq.sv - table-driven and random scoreboard bench for cnu_min_seq
module tb_cnu_min_seq;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic [5:0]  i_deg;
  logic        o_busy;
  logic        i_valid;
  logic        o_ready;
  logic [5:0]  i_data;
  logic        i_sign;
  logic        o_valid;
  logic        i_ready;
  logic [17:0] o_data;
  logic [14:0] o_idx;
  logic        o_sign;

  cnu_min_seq dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (i_start),
    .i_deg   (i_deg),
    .o_busy  (o_busy),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (i_data),
    .i_sign  (i_sign),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (o_data),
    .o_idx   (o_idx),
    .o_sign  (o_sign)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [17:0] d;
    logic [14:0] i;
    logic        s;
  } exp_t;

  typedef struct {
    int   deg;
    int   d [8];
    bit   s [8];
    exp_t e;
    int   vprob;
    int   rmode;
    bit   noise;
  } vec_t;

  int         checks   = 0;
  int         failures = 0;
  exp_t       sb [$];
  exp_t       mon_e;
  logic [5:0] row_d [32];
  logic       row_s [32];
  int         beat;
  vec_t       tbl [8];
  exp_t       cur_e;
  int         rdeg;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Reference: stable sort of three sentinels followed by the beats, keep the first three
  function automatic exp_t model(input int deg);
    logic [5:0] v [35];
    logic [4:0] x [35];
    logic [5:0] tv;
    logic [4:0] tx;
    exp_t       e;
    int         n;
    n = deg + 3;
    for (int k = 0; k < 3; k++) begin
      v[k] = 6'h3f;
      x[k] = 5'h1f;
    end
    for (int b = 0; b < deg; b++) begin
      v[b+3] = row_d[b];
      x[b+3] = b[4:0];
    end
    for (int a = 0; a < n - 1; a++) begin
      for (int j = 0; j < n - 1 - a; j++) begin
        if (v[j] > v[j+1]) begin
          tv = v[j]; v[j] = v[j+1]; v[j+1] = tv;
          tx = x[j]; x[j] = x[j+1]; x[j+1] = tx;
        end
      end
    end
    e.d = {v[2], v[1], v[0]};
    e.i = {x[2], x[1], x[0]};
    e.s = 1'b0;
    for (int b = 0; b < deg; b++) e.s = e.s ^ row_s[b];
    return e;
  endfunction

  task automatic start_row(input int deg);
    i_start = 1'b1;
    i_deg   = 6'(deg);
    @(posedge i_clk); #1;
    i_start = 1'b0;
    beat    = 0;
    chk("busy_at_start", o_busy, 1);
    chk("ready_at_start", o_ready, (deg != 0) ? 1 : 0);
  endtask

  task automatic feed(input int upto, input int vprob, input bit noise);
    int guard;
    bit acc;
    guard = 0;
    while (beat < upto && guard < 2000) begin
      i_valid = ($urandom_range(1, 100) <= vprob);
      i_data  = i_valid ? row_d[beat] : 6'($urandom_range(0, 63));
      i_sign  = i_valid ? row_s[beat] : 1'($urandom_range(0, 1));
      if (noise) begin
        i_start = ($urandom_range(0, 3) == 0);
        i_deg   = 6'($urandom_range(0, 32));
      end
      acc = i_valid && o_ready;
      @(posedge i_clk); #1;
      if (acc) beat++;
      guard++;
    end
    i_valid = 1'b0;
    i_start = 1'b0;
    if (guard >= 2000) timeout_fail("beat_timeout");
  endtask

  // rmode 0: ready high, 1: ready low 6 cycles then high, 2: random ready
  task automatic finish_row(input int rmode, input bit noise, input exp_t e);
    int n;
    bit hs;
    bit done;
    chk("valid_latency", o_valid, 1);
    n    = 0;
    done = 1'b0;
    while (!done && n < 500) begin
      case (rmode)
        0:       i_ready = 1'b1;
        1:       i_ready = (n >= 6);
        default: i_ready = 1'($urandom_range(0, 1));
      endcase
      if (noise) begin
        i_start = ($urandom_range(0, 2) == 0);
        i_deg   = 6'($urandom_range(0, 32));
      end
      if (rmode == 1 && n < 6) begin
        chk("hold_valid", o_valid, 1);
        chk("hold_result", {o_data, o_idx, o_sign}, e);
      end
      hs = o_valid && i_ready;
      @(posedge i_clk); #1;
      if (hs) done = 1'b1;
      n++;
    end
    i_ready = 1'b0;
    i_start = 1'b0;
    if (!done) timeout_fail("result_timeout");
    chk("busy_clear", o_busy, 0);
  endtask

  // Scoreboard: every result handshake pops one expected row
  always @(negedge i_clk) begin
    if (!i_rst && o_valid && i_ready) begin
      if (sb.size() == 0) begin
        timeout_fail("unexpected_result");
      end else begin
        mon_e = sb.pop_front();
        chk("result", {o_data, o_idx, o_sign}, mon_e);
      end
    end
  end

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    i_rst = 1'b1; i_start = 1'b0; i_deg = '0; i_valid = 1'b0;
    i_data = '0; i_sign = 1'b0; i_ready = 1'b0;
    for (int b = 0; b < 32; b++) begin
      row_d[b] = '0;
      row_s[b] = 1'b0;
    end

    tbl[0] = '{deg: 4, d: '{9,3,7,1,0,0,0,0}, s: '{1,0,1,1,0,0,0,0},
               e: '{d: {6'd7,6'd3,6'd1}, i: {5'd2,5'd1,5'd3}, s: 1'b1}, vprob: 100, rmode: 0, noise: 0};
    tbl[1] = '{deg: 5, d: '{5,5,2,5,2,0,0,0}, s: '{1,1,0,0,0,0,0,0},
               e: '{d: {6'd5,6'd2,6'd2}, i: {5'd0,5'd4,5'd2}, s: 1'b0}, vprob: 100, rmode: 0, noise: 0};
    tbl[2] = '{deg: 2, d: '{4,6,0,0,0,0,0,0}, s: '{0,1,0,0,0,0,0,0},
               e: '{d: {6'd63,6'd6,6'd4}, i: {5'd31,5'd1,5'd0}, s: 1'b1}, vprob: 100, rmode: 0, noise: 0};
    tbl[3] = '{deg: 0, d: '{0,0,0,0,0,0,0,0}, s: '{0,0,0,0,0,0,0,0},
               e: '{d: 18'h3ffff, i: 15'h7fff, s: 1'b0}, vprob: 100, rmode: 0, noise: 0};
    tbl[4] = '{deg: 4, d: '{9,3,7,1,0,0,0,0}, s: '{1,0,1,1,0,0,0,0},
               e: '{d: {6'd7,6'd3,6'd1}, i: {5'd2,5'd1,5'd3}, s: 1'b1}, vprob: 50, rmode: 1, noise: 1};
    tbl[5] = '{deg: 5, d: '{5,5,2,5,2,0,0,0}, s: '{1,1,0,0,0,0,0,0},
               e: '{d: {6'd5,6'd2,6'd2}, i: {5'd0,5'd4,5'd2}, s: 1'b0}, vprob: 40, rmode: 1, noise: 1};
    tbl[6] = '{deg: 3, d: '{0,0,0,0,0,0,0,0}, s: '{1,1,1,0,0,0,0,0},
               e: '{d: {6'd0,6'd0,6'd0}, i: {5'd2,5'd1,5'd0}, s: 1'b1}, vprob: 100, rmode: 2, noise: 0};
    tbl[7] = '{deg: 1, d: '{17,0,0,0,0,0,0,0}, s: '{1,0,0,0,0,0,0,0},
               e: '{d: {6'd63,6'd63,6'd17}, i: {5'd31,5'd31,5'd0}, s: 1'b1}, vprob: 100, rmode: 0, noise: 0};

    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_valid", o_valid, 0);
    chk("rst_ready", o_ready, 0);
    chk("rst_busy",  o_busy,  0);
    chk("rst_data",  o_data,  18'h3ffff);
    chk("rst_idx",   o_idx,   15'h7fff);
    chk("rst_sign",  o_sign,  0);
    i_rst = 1'b0;
    @(posedge i_clk); #1;

    // Directed table, rows issued back to back
    for (int t = 0; t < 8; t++) begin
      for (int b = 0; b < 8; b++) begin
        row_d[b] = 6'(tbl[t].d[b]);
        row_s[b] = tbl[t].s[b];
      end
      sb.push_back(tbl[t].e);
      start_row(tbl[t].deg);
      feed(tbl[t].deg, tbl[t].vprob, tbl[t].noise);
      finish_row(tbl[t].rmode, tbl[t].noise, tbl[t].e);
    end

    // Reset in the middle of a deg=8 row, then a clean deg=3 row
    for (int b = 0; b < 8; b++) begin
      row_d[b] = 6'(b + 2);
      row_s[b] = 1'b1;
    end
    start_row(8);
    feed(2, 100, 1'b0);
    i_rst = 1'b1;
    #1;
    chk("midrst_valid", o_valid, 0);
    chk("midrst_ready", o_ready, 0);
    chk("midrst_busy",  o_busy,  0);
    chk("midrst_data",  o_data,  18'h3ffff);
    chk("midrst_idx",   o_idx,   15'h7fff);
    chk("midrst_sign",  o_sign,  0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    @(posedge i_clk); #1;
    for (int b = 0; b < 3; b++) begin
      row_d[b] = 6'd1;
      row_s[b] = 1'b0;
    end
    cur_e = '{d: {6'd1,6'd1,6'd1}, i: {5'd2,5'd1,5'd0}, s: 1'b0};
    sb.push_back(cur_e);
    start_row(3);
    feed(3, 100, 1'b0);
    finish_row(1, 1'b0, cur_e);

    // Random regression against the sort-based model
    for (int r = 0; r < 1000; r++) begin
      rdeg = $urandom_range(0, 32);
      for (int b = 0; b < rdeg; b++) begin
        row_d[b] = 6'($urandom_range(0, 63));
        row_s[b] = 1'($urandom_range(0, 1));
      end
      cur_e = model(rdeg);
      sb.push_back(cur_e);
      start_row(rdeg);
      feed(rdeg, $urandom_range(30, 100), (r % 4) == 0);
      finish_row(2, (r % 4) == 0, cur_e);
    end

    repeat (3) @(posedge i_clk);
    #1;
    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
